// File: rtl/ornor_share_arbiter.sv
// Round-robin arbiter sharing one bitwise OR/NOR unit between two requesters.
// Define ORNOR_ARB_COUNT_EN to add per-requester completed-op counters (cnt0/cnt1).
module ornor_share_arbiter #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             sel0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             sel1,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] res,
   output logic             busy,
   output logic             grant
`ifdef ORNOR_ARB_COUNT_EN
   ,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state, next_state;
   logic             prio;
   logic             winner;
   logic [WIDTH-1:0] op_a, op_b;
   logic             op_sel;
   logic [WIDTH-1:0] unit_or, unit_out;

   // Both requesting -> prio decides; otherwise whoever is asking (req1 alone -> 1).
   assign winner = (req0 && req1) ? prio : req1;

   // Shared datapath sees only the latched operands.
   assign unit_or  = op_a | op_b;
   assign unit_out = op_sel ? unit_or : ~unit_or;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req0 || req1) next_state = EXEC;
         EXEC:    next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign ack0 = (state == DONE) && !grant;
   assign ack1 = (state == DONE) &&  grant;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_a   <= '0;
         op_b   <= '0;
         op_sel <= 1'b0;
         grant  <= 1'b0;
         prio   <= 1'b0;
         res    <= '0;
      end else begin
         case (state)
            IDLE: if (req0 || req1) begin
               op_a   <= winner ? a1   : a0;
               op_b   <= winner ? b1   : b0;
               op_sel <= winner ? sel1 : sel0;
               grant  <= winner;
            end
            EXEC: res  <= unit_out;
            DONE: prio <= ~grant;
            default: ;
         endcase
      end
   end

`ifdef ORNOR_ARB_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (state == DONE) begin
         if (grant) cnt1 <= cnt1 + 1'b1;
         else       cnt0 <= cnt0 + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ornor_share_arbiter.sv
// Directed self-checking bench for ornor_share_arbiter (WIDTH=4).
// With ORNOR_ARB_COUNT_EN defined the counters are built with CNT_W=2 and checked for wrap.
module tb_ornor_share_arbiter;

`ifdef ORNOR_ARB_COUNT_EN
   localparam int TB_CNT_W = 2;
`else
   localparam int TB_CNT_W = 8;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req0, sel0, req1, sel1;
   logic [3:0] a0, b0, a1, b1;
   logic       ack0, ack1, busy, grant;
   logic [3:0] res;
`ifdef ORNOR_ARB_COUNT_EN
   logic [TB_CNT_W-1:0] cnt0, cnt1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   ornor_share_arbiter #(.WIDTH(4), .CNT_W(TB_CNT_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .a0(a0), .b0(b0), .sel0(sel0),
      .req1(req1), .a1(a1), .b1(b1), .sel1(sel1),
      .ack0(ack0), .ack1(ack1), .res(res), .busy(busy), .grant(grant)
`ifdef ORNOR_ARB_COUNT_EN
      , .cnt0(cnt0), .cnt1(cnt1)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic e_ack0, input logic e_ack1,
                          input logic [3:0] e_res, input logic e_busy, input logic e_grant);
      chk({tag, ".ack0"},  {31'd0, ack0},  {31'd0, e_ack0});
      chk({tag, ".ack1"},  {31'd0, ack1},  {31'd0, e_ack1});
      chk({tag, ".res"},   {28'd0, res},   {28'd0, e_res});
      chk({tag, ".busy"},  {31'd0, busy},  {31'd0, e_busy});
      chk({tag, ".grant"}, {31'd0, grant}, {31'd0, e_grant});
   endtask

   initial begin
      reset_n = 1'b0;
      req0 = 1'b0; a0 = 4'h0; b0 = 4'h0; sel0 = 1'b0;
      req1 = 1'b0; a1 = 4'h0; b1 = 4'h0; sel1 = 1'b0;

      // Held in reset while requests toggle: everything stays at reset values.
      for (int i = 0; i < 3; i++) begin
         req0 = i[0]; req1 = ~i[0];
         step();
         chk_all("rst_hold", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      end
      req0 = 1'b0; req1 = 1'b0;
      reset_n = 1'b1;
      step();
      chk_all("idle", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

      // Requester 0 OR: 0101|0011 = 0111.
      req0 = 1'b1; a0 = 4'b0101; b0 = 4'b0011; sel0 = 1'b1;
      step();
      chk_all("or0_exec", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      step();
      chk_all("or0_done", 1'b1, 1'b0, 4'b0111, 1'b1, 1'b0);
      req0 = 1'b0;
      step();
      chk_all("or0_idle", 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0);

      // Requester 1 NOR: ~(0101|0011) = 1000.
      req1 = 1'b1; a1 = 4'b0101; b1 = 4'b0011; sel1 = 1'b0;
      step();
      chk_all("nor1_exec", 1'b0, 1'b0, 4'b0111, 1'b1, 1'b1);
      step();
      chk_all("nor1_done", 1'b0, 1'b1, 4'b1000, 1'b1, 1'b1);
      req1 = 1'b0;
      step();
      chk_all("nor1_idle", 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);

      // Operand change during EXEC ignored: NOR of 0,0 = 1111 even though a0 goes to 1111.
      req0 = 1'b1; a0 = 4'h0; b0 = 4'h0; sel0 = 1'b0;
      step();
      a0 = 4'hF; sel0 = 1'b1;
      step();
      chk_all("frozen_done", 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
      req0 = 1'b0;
      step();

      // Fresh reset, both request: op0 first (ack0 cycle 2), op1 next (ack1 cycle 5).
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      req0 = 1'b1; a0 = 4'b0001; b0 = 4'b0010; sel0 = 1'b1;
      req1 = 1'b1; a1 = 4'b0100; b1 = 4'b0000; sel1 = 1'b0;
      step();
      chk_all("both_c1", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      step();
      chk_all("both_c2", 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0);
      req0 = 1'b0;
      step();
      chk_all("both_c3", 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0);
      step();
      chk_all("both_c4", 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1);
      step();
      chk_all("both_c5", 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
      req1 = 1'b0;
      step();

      // Both held continuously: strict alternation 0,1,0,1 starting with 0 (prio flipped by op1).
      req0 = 1'b1; a0 = 4'b1000; b0 = 4'b0001; sel0 = 1'b1;
      req1 = 1'b1; a1 = 4'b0000; b1 = 4'b0100; sel1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         step();
         if (i % 2 == 0) chk_all("alt_done", 1'b1, 1'b0, 4'b1001, 1'b1, 1'b0);
         else            chk_all("alt_done", 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
         step();
      end
      req0 = 1'b0; req1 = 1'b0;
      step();
      chk_all("alt_idle", 1'b0, 1'b0, 4'b1011, 1'b0, 1'b1);

      // Reset asserted in the middle of EXEC: immediate clear, op discarded, no ack.
      req0 = 1'b1; a0 = 4'b0101; b0 = 4'b0011; sel0 = 1'b1;
      step();
      chk("mid_exec.busy", {31'd0, busy}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all("mid_rst", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      step();
      chk_all("mid_rst_hold", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      reset_n = 1'b1;
      step();
      chk_all("re_exec", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      step();
      chk_all("re_done", 1'b1, 1'b0, 4'b0111, 1'b1, 1'b0);
      req0 = 1'b0;
      step();

`ifdef ORNOR_ARB_COUNT_EN
      // Counter wrap with CNT_W=2: 0,1,2,3,0,1 across five ops on requester 0.
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      chk("cnt0_init", {30'd0, cnt0}, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         req0 = 1'b1;
         step();
         step();
         req0 = 1'b0;
         step();
         chk("cnt0_seq", {30'd0, cnt0}, i % 4);
         chk("cnt1_zero", {30'd0, cnt1}, 32'd0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
